// File: rtl/ysyx_sq_if.sv
// ysyx_sq_if: the committed-store queue's bus signals. This covers the ROB
// commit channel, the L1D write channel, the load-forwarding lookup and the
// drain status. The slave modport is the queue; the master modport is its
// environment (ROB, L1D and the load pipe).
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface ysyx_sq_if #(
  parameter int unsigned XLEN = `YSYX_XLEN
) ();
  logic            commit_valid;
  logic [XLEN-1:0] commit_addr;
  logic [XLEN-1:0] commit_data;
  logic [3:0]      commit_walu;
  logic            commit_ready;

  logic            l1d_wvalid;
  logic [XLEN-1:0] l1d_waddr;
  logic [XLEN-1:0] l1d_wdata;
  logic [3:0]      l1d_walu;
  logic            l1d_wready;

  logic [XLEN-1:0] ld_addr;
  logic            ld_hit;
  logic [XLEN-1:0] ld_fwd_data;
  logic            ld_conflict;

  logic            drained;

  modport slave (
    input  commit_valid, commit_addr, commit_data, commit_walu,
    output commit_ready,
    output l1d_wvalid, l1d_waddr, l1d_wdata, l1d_walu,
    input  l1d_wready,
    input  ld_addr,
    output ld_hit, ld_fwd_data, ld_conflict,
    output drained
  );

  modport master (
    output commit_valid, commit_addr, commit_data, commit_walu,
    input  commit_ready,
    input  l1d_wvalid, l1d_waddr, l1d_wdata, l1d_walu,
    output l1d_wready,
    output ld_addr,
    input  ld_hit, ld_fwd_data, ld_conflict,
    input  drained
  );
endinterface

// File: rtl/ysyx_sq.sv
// ysyx_sq: committed-store queue. It buffers committed stores in a circular
// FIFO and drains the head into the L1D write port one entry at a time.
// Younger loads get forwarded data from the youngest matching word, or a
// conflict flag when that youngest match is a partial-word store. A pipeline
// flush never touches this queue, because every entry has already committed.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_sq #(
  parameter int unsigned SQ_DEPTH = 4,
  parameter int unsigned XLEN     = `YSYX_XLEN
) (
  input logic       clock,
  input logic       reset,
  ysyx_sq_if.slave  sq
);

  localparam int unsigned IW      = $clog2(SQ_DEPTH);
  localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

  // Pointers carry one extra wrap bit above the index bits, so that full and
  // empty can be told apart when the index bits are equal.
  logic [IW:0]     r_head;
  logic [IW:0]     r_tail;
  logic [XLEN-1:0] r_addr [SQ_DEPTH];
  logic [XLEN-1:0] r_data [SQ_DEPTH];
  logic [3:0]      r_walu [SQ_DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_enq;
  logic            w_deq;
  logic [IW:0]     w_count;
  logic [IW-1:0]   w_head_idx;

  logic [IW-1:0]   w_scan_idx;
  logic            w_match_any;
  logic            w_young_full;
  logic [XLEN-1:0] w_young_data;
  logic            w_hit;

  assign w_head_idx = r_head[IW-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
  assign w_count    = r_tail - r_head;

  // Readiness comes from registered state only. A slot freed by this cycle's
  // dequeue becomes available to commits in the next cycle.
  assign w_enq = sq.commit_valid && !w_full;
  assign w_deq = !w_empty && sq.l1d_wready;

  // Pointer advance and entry write. Reset clears every entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_walu[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail[IW-1:0]] <= sq.commit_addr;
        r_data[r_tail[IW-1:0]] <= sq.commit_data;
        r_walu[r_tail[IW-1:0]] <= sq.commit_walu;
        r_tail                 <= r_tail + PTR_ONE;
      end
      if (w_deq) begin
        r_head <= r_head + PTR_ONE;
      end
    end
  end

  // Head presentation. The head fields read as zero whenever the queue is
  // empty, so no stale entry reaches the write channel.
  assign sq.commit_ready = !w_full;
  assign sq.l1d_wvalid   = !w_empty;
  assign sq.l1d_waddr    = w_empty ? '0 : r_addr[w_head_idx];
  assign sq.l1d_wdata    = w_empty ? '0 : r_data[w_head_idx];
  assign sq.l1d_walu     = w_empty ? '0 : r_walu[w_head_idx];
  assign sq.drained      = w_empty;

  // Forwarding scan runs from oldest to youngest valid entry. Each later
  // match overrides the earlier ones, so the youngest matching entry decides.
  always_comb begin
    w_scan_idx   = '0;
    w_match_any  = 1'b0;
    w_young_full = 1'b0;
    w_young_data = '0;
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      w_scan_idx = w_head_idx + IW'(i);
      if (((IW+1)'(i) < w_count) &&
          (r_addr[w_scan_idx][XLEN-1:2] == sq.ld_addr[XLEN-1:2])) begin
        w_match_any  = 1'b1;
        w_young_full = (r_walu[w_scan_idx] == 4'hf);
        w_young_data = r_data[w_scan_idx];
      end
    end
  end

  assign w_hit           = w_match_any && w_young_full;
  assign sq.ld_hit       = w_hit;
  assign sq.ld_conflict  = w_match_any && !w_young_full;
  assign sq.ld_fwd_data  = w_hit ? w_young_data : '0;

endmodule
